// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared widths, FSM state type and latched request type
// for the memory-port arbiter.
package mem_arbiter_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
        logic              write;
    } mem_req_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: single memory port (request + response channels) shared
// by all requesters. The arbiter is the master, the bus adapter the slave.
interface mem_arbiter_if #(
    parameter int ADDR_W = mem_arbiter_pkg::ADDR_W,
    parameter int DATA_W = mem_arbiter_pkg::DATA_W
);
    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_wstrb;
    logic                  mem_write;
    logic                  mem_rsp_valid;
    logic [DATA_W-1:0]     mem_rsp_rdata;

    modport master (
        output mem_req_valid, mem_addr, mem_wdata, mem_wstrb, mem_write,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata
    );

    modport slave (
        input  mem_req_valid, mem_addr, mem_wdata, mem_wstrb, mem_write,
        output mem_req_ready, mem_rsp_valid, mem_rsp_rdata
    );
endinterface

// File: rtl/mem_arbiter_rr_picker.sv
// rr_picker: combinational round-robin selector. Starting just after the
// previous winner and wrapping around, it reports the first valid requester.
// Kept generic so the other arbiters in the design can reuse it.
module rr_picker #(
    parameter  int N_REQ = 2,
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] valid_i,
    input  logic [IDX_W-1:0] last_i,
    output logic             any_o,
    output logic [IDX_W-1:0] winner_o
);

    int               idx;
    logic [IDX_W-1:0] candidate;

    // Scan upward from last+1 modulo N_REQ and keep the first valid slot found.
    always_comb begin
        any_o     = 1'b0;
        winner_o  = '0;
        idx       = 0;
        candidate = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx       = (int'(last_i) + k) % N_REQ;
            candidate = IDX_W'(idx);
            if (!any_o && valid_i[candidate]) begin
                any_o    = 1'b1;
                winner_o = candidate;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one memory port between N_REQ
// requesters (0 = fetch, 1 = load/store). One transaction outstanding at a
// time: IDLE picks and latches, ISSUE presents the request, WAIT steers the
// response back to the granted requester.
module mem_arbiter #(
    parameter  int N_REQ  = 2,
    parameter  int ADDR_W = mem_arbiter_pkg::ADDR_W,
    parameter  int DATA_W = mem_arbiter_pkg::DATA_W,
    localparam int STRB_W = DATA_W / 8,
    localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req_valid_i,
    output logic [N_REQ-1:0]        req_ready_o,
    input  logic [N_REQ*ADDR_W-1:0] req_addr_i,
    input  logic [N_REQ*DATA_W-1:0] req_wdata_i,
    input  logic [N_REQ*STRB_W-1:0] req_wstrb_i,
    input  logic [N_REQ-1:0]        req_write_i,
    output logic [N_REQ-1:0]        rsp_valid_o,
    output logic [DATA_W-1:0]       rsp_rdata_o,
    mem_arbiter_if.master           mem,
    output logic                    spurious_rsp_o
);

    import mem_arbiter_pkg::*;

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    mem_req_t         memReq_q, memReq_d;
    logic             spurious_q, spurious_d;

    logic             pickAny;
    logic [IDX_W-1:0] pickIdx;

    rr_picker #(.N_REQ(N_REQ)) picker (
        .valid_i  (req_valid_i),
        .last_i   (last_q),
        .any_o    (pickAny),
        .winner_o (pickIdx)
    );

    // State, fairness pointer and latched request; reset abandons any transaction in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            last_q     <= IDX_W'(N_REQ - 1);
            grant_q    <= '0;
            memReq_q   <= '0;
            spurious_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            grant_q    <= grant_d;
            memReq_q   <= memReq_d;
            spurious_q <= spurious_d;
        end
    end

    // Next-state logic with the combinational ready grant and response steering.
    always_comb begin
        state_d           = state_q;
        last_d            = last_q;
        grant_d           = grant_q;
        memReq_d          = memReq_q;
        spurious_d        = spurious_q | (mem.mem_rsp_valid && (state_q != WAIT));
        req_ready_o       = '0;
        rsp_valid_o       = '0;
        mem.mem_req_valid = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (pickAny) begin
                    req_ready_o[pickIdx] = 1'b1;
                    grant_d              = pickIdx;
                    memReq_d.addr        = req_addr_i[pickIdx*ADDR_W +: ADDR_W];
                    memReq_d.wdata       = req_wdata_i[pickIdx*DATA_W +: DATA_W];
                    memReq_d.wstrb       = req_wstrb_i[pickIdx*STRB_W +: STRB_W];
                    memReq_d.write       = req_write_i[pickIdx];
                    state_d              = ISSUE;
                end
            end
            ISSUE: begin
                mem.mem_req_valid = 1'b1;
                if (mem.mem_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                rsp_valid_o[grant_q] = mem.mem_rsp_valid;
                if (mem.mem_rsp_valid) begin
                    last_d  = grant_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem.mem_addr   = memReq_q.addr;
    assign mem.mem_wdata  = memReq_q.wdata;
    assign mem.mem_wstrb  = memReq_q.wstrb;
    assign mem.mem_write  = memReq_q.write;
    assign rsp_rdata_o    = mem.mem_rsp_rdata;
    assign spurious_rsp_o = spurious_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic for mem_arbiter.
// Expectations come from a transaction-level reference model and are queued
// by the driver; a separate monitor pops them whenever the DUT shows output.
module tb_mem_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic [N-1:0]      reqValid;
    logic [N-1:0]      reqReady;
    logic [N*AW-1:0]   reqAddr;
    logic [N*DW-1:0]   reqWdata;
    logic [N*SW-1:0]   reqWstrb;
    logic [N-1:0]      reqWrite;
    logic [N-1:0]      rspValid;
    logic [DW-1:0]     rspRdata;
    logic              spurious;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) memBus ();

    mem_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clock          (clock),
        .reset          (reset),
        .req_valid_i    (reqValid),
        .req_ready_o    (reqReady),
        .req_addr_i     (reqAddr),
        .req_wdata_i    (reqWdata),
        .req_wstrb_i    (reqWstrb),
        .req_write_i    (reqWrite),
        .rsp_valid_o    (rspValid),
        .rsp_rdata_o    (rspRdata),
        .mem            (memBus),
        .spurious_rsp_o (spurious)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] wstrb;
        logic          write;
    } txn_t;

    typedef struct {
        int            id;
        logic [DW-1:0] data;
    } rsp_t;

    txn_t         pendQ[N][$];
    txn_t         memExpQ[$];
    int           grantQ[$];
    rsp_t         rspExpQ[$];
    int           grantLog[$];
    logic [N-1:0] rspLog[$];

    int            phase;
    int            lastId;
    int            grantId;
    bit            spurExp;
    int            validPct  = 100;
    int            readyPct  = 100;
    int            rspPct    = 100;
    bit            genEnable = 1'b0;
    bit            spurPulse = 1'b0;
    bit            useFixed  = 1'b0;
    logic [DW-1:0] fixedVal  = '0;

    int   checks     = 0;
    int   errors     = 0;
    int   memHsCount = 0;
    int   hsBefore;
    int   gId;
    txn_t mExp;
    rsp_t rExp;

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic noteFailure(input string name, input string what);
        checks++;
        errors++;
        $display("[TB] FAIL %s: %s at %0t", name, what, $time);
    endtask

    function automatic txn_t randTxn();
        txn_t t;
        t.addr  = $urandom;
        t.wdata = $urandom;
        t.wstrb = SW'($urandom);
        t.write = 1'($urandom);
        return t;
    endfunction

    function automatic int pickNext(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    function automatic int onehotIdx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [127:0] packGrants();
        logic [127:0] p = '0;
        foreach (grantLog[i]) begin
            if (i < 32) p[i*4 +: 4] = 4'(grantLog[i] + 1);
        end
        return p;
    endfunction

    function automatic logic [127:0] packRsps();
        logic [127:0] p = '0;
        foreach (rspLog[i]) begin
            if (i < 32) p[i*4 +: 4] = 4'(rspLog[i]);
        end
        return p;
    endfunction

    function automatic bit drained();
        bit d = (phase == 0);
        for (int i = 0; i < N; i++) begin
            if (pendQ[i].size() != 0) d = 1'b0;
        end
        return d;
    endfunction

    // One clock cycle: drive requesters and memory, then advance the reference model.
    task automatic applyStimulus();
        int startPhase;
        int w;
        @(posedge clock);
        #1;
        if (genEnable) begin
            for (int i = 0; i < N; i++) begin
                if (pendQ[i].size() < 2 && $urandom_range(99) < 30) pendQ[i].push_back(randTxn());
            end
        end
        for (int i = 0; i < N; i++) begin
            if (pendQ[i].size() > 0 && $urandom_range(99) < validPct) begin
                reqValid[i]            = 1'b1;
                reqAddr[i*AW +: AW]    = pendQ[i][0].addr;
                reqWdata[i*DW +: DW]   = pendQ[i][0].wdata;
                reqWstrb[i*SW +: SW]   = pendQ[i][0].wstrb;
                reqWrite[i]            = pendQ[i][0].write;
            end else begin
                reqValid[i]            = 1'b0;
                reqAddr[i*AW +: AW]    = $urandom;
                reqWdata[i*DW +: DW]   = $urandom;
                reqWstrb[i*SW +: SW]   = SW'($urandom);
                reqWrite[i]            = 1'($urandom);
            end
        end
        startPhase = phase;
        memBus.mem_req_ready = (startPhase == 1) ? ($urandom_range(99) < readyPct) : 1'($urandom);
        memBus.mem_rsp_valid = spurPulse || (startPhase == 2 && $urandom_range(99) < rspPct);
        memBus.mem_rsp_rdata = useFixed ? fixedVal : $urandom;

        if (memBus.mem_rsp_valid && startPhase != 2) spurExp = 1'b1;
        case (startPhase)
            0: begin
                w = pickNext(reqValid, lastId);
                if (w >= 0) begin
                    grantQ.push_back(w);
                    memExpQ.push_back(pendQ[w].pop_front());
                    grantId = w;
                    phase   = 1;
                end
            end
            1: begin
                if (memBus.mem_req_ready) phase = 2;
            end
            default: begin
                if (memBus.mem_rsp_valid) begin
                    rspExpQ.push_back(rsp_t'{grantId, memBus.mem_rsp_rdata});
                    lastId = grantId;
                    phase  = 0;
                end
            end
        endcase
    endtask

    task automatic doReset();
        @(posedge clock);
        #1;
        reset                = 1'b0;
        reqValid             = '0;
        memBus.mem_req_ready = 1'b0;
        memBus.mem_rsp_valid = 1'b0;
        phase                = 0;
        lastId               = N - 1;
        grantId              = 0;
        spurExp              = 1'b0;
        grantQ.delete();
        memExpQ.delete();
        rspExpQ.delete();
        for (int i = 0; i < N; i++) pendQ[i].delete();
        @(negedge clock);
        #1;
        checkOutput("reset_mem_req_valid", 128'(memBus.mem_req_valid), 128'(0));
        checkOutput("reset_rsp_valid", 128'(rspValid), 128'(0));
        checkOutput("reset_req_ready", 128'(reqReady), 128'(0));
        checkOutput("reset_spurious", 128'(spurious), 128'(0));
        checkOutput("reset_mem_fields",
                    128'({memBus.mem_addr, memBus.mem_wdata, memBus.mem_wstrb, memBus.mem_write}), 128'(0));
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    task automatic stepAndSettle();
        applyStimulus();
        @(negedge clock);
        #1;
    endtask

    task automatic waitDrained(input string name, input int limit);
        int n = 0;
        while (!drained() && n < limit) begin
            applyStimulus();
            n++;
        end
        if (!drained()) noteFailure(name, "timed out, expected all transactions to complete");
        @(negedge clock);
        #1;
    endtask

    task automatic waitPhase(input string name, input int target, input int limit);
        int n = 0;
        while (phase != target && n < limit) begin
            applyStimulus();
            n++;
        end
        if (phase != target) noteFailure(name, "timed out, expected memory acceptance");
    endtask

    // Scoreboard monitor: pop an expectation whenever the DUT grants, hands off to memory or responds.
    always @(negedge clock) begin
        if (reqReady != '0) begin
            grantLog.push_back(onehotIdx(reqReady));
            if (grantQ.size() == 0) begin
                noteFailure("grant", $sformatf("got ready %b, expected no grant", reqReady));
            end else begin
                gId = grantQ.pop_front();
                checkOutput("grant", 128'(reqReady), 128'(N'(1) << gId));
            end
        end
        if (memBus.mem_req_valid && memBus.mem_req_ready) begin
            memHsCount++;
            if (memExpQ.size() == 0) begin
                noteFailure("mem_req", $sformatf("got handshake addr %0h, expected none", memBus.mem_addr));
            end else begin
                mExp = memExpQ.pop_front();
                checkOutput("mem_req",
                    128'({memBus.mem_addr, memBus.mem_wdata, memBus.mem_wstrb, memBus.mem_write}),
                    128'({mExp.addr, mExp.wdata, mExp.wstrb, mExp.write}));
            end
        end
        if (rspValid != '0) begin
            rspLog.push_back(rspValid);
            if (rspExpQ.size() == 0) begin
                noteFailure("rsp", $sformatf("got rsp_valid %b, expected none", rspValid));
            end else begin
                rExp = rspExpQ.pop_front();
                checkOutput("rsp", 128'({rspValid, rspRdata}), 128'({N'(1) << rExp.id, rExp.data}));
            end
        end
    end

    // Hard stop in case something upstream never returns.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reqValid             = '0;
        reqAddr              = '0;
        reqWdata             = '0;
        reqWstrb             = '0;
        reqWrite             = '0;
        memBus.mem_req_ready = 1'b0;
        memBus.mem_rsp_valid = 1'b0;
        memBus.mem_rsp_rdata = '0;
        phase                = 0;
        lastId               = N - 1;
        grantId              = 0;
        spurExp              = 1'b0;

        $display("[TB] single read");
        doReset();
        pendQ[0].push_back(txn_t'{32'h100, 32'h0, 4'h0, 1'b0});
        useFixed = 1'b1;
        fixedVal = 32'hDEADBEEF;
        stepAndSettle();
        checkOutput("single_ready", 128'(reqReady), 128'(2'b01));
        stepAndSettle();
        checkOutput("single_mem_valid", 128'(memBus.mem_req_valid), 128'(1));
        checkOutput("single_mem_addr", 128'(memBus.mem_addr), 128'(32'h100));
        stepAndSettle();
        checkOutput("single_rsp_valid", 128'(rspValid), 128'(2'b01));
        checkOutput("single_rsp_rdata", 128'(rspRdata), 128'(32'hDEADBEEF));
        useFixed = 1'b0;
        stepAndSettle();
        checkOutput("single_back_idle", 128'({memBus.mem_req_valid, rspValid}), 128'(0));

        $display("[TB] simultaneous requests");
        doReset();
        grantLog.delete();
        rspLog.delete();
        pendQ[0].push_back(randTxn());
        pendQ[1].push_back(randTxn());
        waitDrained("simul_drain", 50);
        checkOutput("simul_grant_order", packGrants(), 128'h21);
        checkOutput("simul_rsp_order", packRsps(), 128'h21);

        $display("[TB] sustained contention");
        doReset();
        grantLog.delete();
        readyPct = 60;
        rspPct   = 50;
        for (int i = 0; i < 4; i++) begin
            pendQ[0].push_back(randTxn());
            pendQ[1].push_back(randTxn());
        end
        waitDrained("contention_drain", 400);
        checkOutput("contention_order", packGrants(), 128'h2121_2121);

        $display("[TB] memory stall");
        doReset();
        readyPct = 0;
        rspPct   = 100;
        pendQ[0].push_back(txn_t'{32'h40, 32'h12345678, 4'b0011, 1'b1});
        pendQ[1].push_back(randTxn());
        hsBefore = memHsCount;
        stepAndSettle();
        checkOutput("stall_grant", 128'(reqReady), 128'(2'b01));
        for (int k = 0; k < 5; k++) begin
            stepAndSettle();
            checkOutput("stall_valid", 128'(memBus.mem_req_valid), 128'(1));
            checkOutput("stall_fields",
                128'({memBus.mem_addr, memBus.mem_wdata, memBus.mem_wstrb, memBus.mem_write}),
                128'({32'h40, 32'h12345678, 4'b0011, 1'b1}));
            checkOutput("stall_req_ready", 128'(reqReady), 128'(0));
        end
        readyPct = 100;
        rspPct   = 0;
        stepAndSettle();
        stepAndSettle();
        checkOutput("stall_handshakes", 128'(memHsCount - hsBefore), 128'(1));
        rspPct = 100;
        waitDrained("stall_drain", 50);

        $display("[TB] reset in WAIT");
        doReset();
        readyPct = 100;
        rspPct   = 0;
        pendQ[0].push_back(randTxn());
        waitPhase("wait_reach", 2, 20);
        doReset();
        grantLog.delete();
        rspPct = 100;
        pendQ[0].push_back(randTxn());
        pendQ[1].push_back(randTxn());
        waitDrained("post_reset_drain", 50);
        checkOutput("post_reset_order", packGrants(), 128'h21);

        $display("[TB] spurious response");
        doReset();
        spurPulse = 1'b1;
        stepAndSettle();
        spurPulse = 1'b0;
        checkOutput("spur_rsp_valid", 128'(rspValid), 128'(0));
        stepAndSettle();
        checkOutput("spur_flag", 128'(spurious), 128'(1));
        repeat (3) stepAndSettle();
        checkOutput("spur_sticky", 128'(spurious), 128'(spurExp));

        $display("[TB] randomized traffic");
        doReset();
        genEnable = 1'b1;
        validPct  = 70;
        readyPct  = 50;
        rspPct    = 40;
        repeat (1500) applyStimulus();
        genEnable = 1'b0;
        validPct  = 100;
        readyPct  = 100;
        rspPct    = 100;
        waitDrained("random_drain", 200);
        checkOutput("leftover_grants", 128'(grantQ.size()), 128'(0));
        checkOutput("leftover_mem_reqs", 128'(memExpQ.size()), 128'(0));
        checkOutput("leftover_rsps", 128'(rspExpQ.size()), 128'(0));
        checkOutput("final_spurious", 128'(spurious), 128'(spurExp));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
